// File: rtl/collision_score.sv
// rtl/collision_score.sv - bird/pipe/ground collision detection, pipe-cleared BCD scoring and game FSM
module collision_score #(
    parameter int BIRD_X   = 200,
    parameter int BIRD_W   = 20,
    parameter int BIRD_H   = 20,
    parameter int PIPE_W   = 60,
    parameter int GAP_H    = 120,
    parameter int GROUND_Y = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [9:0]  BirdPosY,
    input  logic [9:0]  PipePosX,
    input  logic [9:0]  PipePosY,
    output logic        Lost,
    output logic [11:0] Score,
    output logic        ScoreTick,
    output logic        Playing
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        LOST = 2'd2
    } state_t;

    localparam logic [10:0] BIRD_L   = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R   = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] BIRD_HT  = 11'(BIRD_H);
    localparam logic [10:0] PIPE_WD  = 11'(PIPE_W);
    localparam logic [10:0] GAP_HT   = 11'(GAP_H);
    localparam logic [10:0] GROUND   = 11'(GROUND_Y);

    state_t      state, state_next;
    logic        start_q;
    logic        start_rise;
    logic [9:0]  by, px, py;
    logic        passed, passed_next;
    logic [11:0] score_next;
    logic        tick_next;

    logic [10:0] by_w, px_w, py_w;
    logic        x_ovl, y_out, hit, cleared, respawn;

    // All geometry is evaluated in 11 bits so px near 1023 cannot wrap into an overlap.
    assign by_w = {1'b0, by};
    assign px_w = {1'b0, px};
    assign py_w = {1'b0, py};

    assign x_ovl   = (px_w < BIRD_R) && (px_w + PIPE_WD > BIRD_L);
    assign y_out   = (by_w < py_w) || (by_w + BIRD_HT > py_w + GAP_HT);
    assign hit     = (x_ovl && y_out) || (by_w + BIRD_HT >= GROUND);
    assign cleared = (px_w + PIPE_WD <= BIRD_L) && !passed;
    assign respawn = (px_w >= BIRD_R);

    assign start_rise = Start & ~start_q;
    assign Lost       = (state == LOST);
    assign Playing    = (state == PLAY);

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, o;
        {h, t, o} = v;
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            by        <= '0;
            px        <= '0;
            py        <= '0;
            passed    <= 1'b0;
            Score     <= 12'h000;
            ScoreTick <= 1'b0;
        end else begin
            state     <= state_next;
            start_q   <= Start;
            by        <= BirdPosY;
            px        <= PipePosX;
            py        <= PipePosY;
            passed    <= passed_next;
            Score     <= score_next;
            ScoreTick <= tick_next;
        end
    end

    always_comb begin
        state_next  = state;
        passed_next = passed;
        score_next  = Score;
        tick_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next  = PLAY;
                    score_next  = 12'h000;
                    passed_next = 1'b0;
                end
            end
            PLAY: begin
                if (hit) begin
                    state_next = LOST;
                end else begin
                    if (cleared) begin
                        passed_next = 1'b1;
                        // 999 saturates silently: no increment and no tick.
                        if (Score != 12'h999) begin
                            score_next = bcd_inc(Score);
                            tick_next  = 1'b1;
                        end
                    end
                    if (respawn) begin
                        passed_next = 1'b0;
                    end
                end
            end
            LOST: begin
                if (start_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_collision_score.sv
// tb/tb_collision_score.sv - scoreboard bench for collision_score against a behavioural game model
module tb_collision_score;

    localparam int BX = 200, BW = 20, BH = 20, PW = 60, GH = 120, GY = 480;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  bird_y, pipe_x, pipe_y;
    logic        lost;
    logic [11:0] score;
    logic        score_tick;
    logic        playing;

    collision_score dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .BirdPosY  (bird_y),
        .PipePosX  (pipe_x),
        .PipePosY  (pipe_y),
        .Lost      (lost),
        .Score     (score),
        .ScoreTick (score_tick),
        .Playing   (playing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lost;
        logic [11:0] score;
        logic        tick;
        logic        playing;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;

    // Reference model state: 0 idle, 1 play, 2 lost; score kept as a plain integer.
    int m_state = 0, m_score = 0, m_passed = 0, m_startq = 0, m_tick = 0;
    int m_by = 0, m_px = 0, m_py = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic model_edge(input int r, input int st, input int yb, input int xp, input int yp);
        int rise, x_ovl, y_out, hit, clr, resp;
        if (r != 0) begin
            m_state = 0; m_score = 0; m_passed = 0; m_startq = 0; m_tick = 0;
            m_by = 0; m_px = 0; m_py = 0;
        end else begin
            rise  = (st != 0 && m_startq == 0) ? 1 : 0;
            x_ovl = (m_px < BX + BW && m_px + PW > BX) ? 1 : 0;
            y_out = (m_by < m_py || m_by + BH > m_py + GH) ? 1 : 0;
            hit   = ((x_ovl != 0 && y_out != 0) || m_by + BH >= GY) ? 1 : 0;
            clr   = (m_px + PW <= BX && m_passed == 0) ? 1 : 0;
            resp  = (m_px >= BX + BW) ? 1 : 0;
            m_tick = 0;
            if (m_state == 0) begin
                if (rise != 0) begin
                    m_state = 1; m_score = 0; m_passed = 0;
                end
            end else if (m_state == 1) begin
                if (hit != 0) begin
                    m_state = 2;
                end else begin
                    if (clr != 0) begin
                        m_passed = 1;
                        if (m_score < 999) begin
                            m_score++;
                            m_tick = 1;
                        end
                    end
                    if (resp != 0) m_passed = 0;
                end
            end else begin
                if (rise != 0) m_state = 0;
            end
            m_startq = st;
            m_by = yb; m_px = xp; m_py = yp;
        end
    endtask

    task automatic step(input int r, input int st, input int yb, input int xp, input int yp);
        exp_t e, got;
        rst    = (r != 0);
        start  = (st != 0);
        bird_y = 10'(yb);
        pipe_x = 10'(xp);
        pipe_y = 10'(yp);
        model_edge(r, st, yb, xp, yp);
        e.lost    = (m_state == 2);
        e.score   = to_bcd(m_score);
        e.tick    = (m_tick != 0);
        e.playing = (m_state == 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        if (score_tick) tick_seen++;
        check("sb_lost", 32'(lost), 32'(got.lost));
        check("sb_score", 32'(score), 32'(got.score));
        check("sb_tick", 32'(score_tick), 32'(got.tick));
        check("sb_playing", 32'(playing), 32'(got.playing));
    endtask

    // Scores n pipes: each pass puts the pipe left of the bird, then respawns it at the far right.
    task automatic do_passes(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 200, 140, 180);
            step(0, 0, 200, 1023, 180);
        end
        step(0, 0, 200, 1023, 180);
        step(0, 0, 200, 1023, 180);
    endtask

    task automatic restart();
        step(0, 1, 200, 1023, 180);
        step(0, 0, 200, 1023, 180);
        step(0, 1, 200, 1023, 180);
        check("restart_play", 32'(playing), 32'd1);
        check("restart_score0", 32'(score), 32'h000);
        step(0, 0, 200, 1023, 180);
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b1; bird_y = 10'd200; pipe_x = 10'd800; pipe_y = 10'd180;

        // Reset with Start held high; the first post-reset cycle counts as a rise.
        step(1, 1, 200, 800, 180);
        step(1, 1, 200, 800, 180);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_score", 32'(score), 32'h000);
        check("rst_tick", 32'(score_tick), 32'd0);
        check("rst_playing", 32'(playing), 32'd0);
        step(0, 1, 200, 800, 180);
        check("start_after_reset", 32'(playing), 32'd1);
        step(0, 0, 200, 800, 180);

        // Single pipe sweep through the gap.
        tick_seen = 0;
        for (int x = 800; x >= 0; x -= 5) step(0, 0, 200, x, 180);
        step(0, 0, 200, 0, 180);
        step(0, 0, 200, 0, 180);
        check("sweep1_score", 32'(score), 32'h001);
        check("sweep1_ticks", 32'(tick_seen), 32'd1);
        check("sweep1_lost", 32'(lost), 32'd0);

        // Wrap through 0 to 1023 clears passed; the next pipe scores exactly once.
        tick_seen = 0;
        step(0, 0, 200, 1, 180);
        step(0, 0, 200, 0, 180);
        step(0, 0, 200, 1023, 180);
        step(0, 0, 200, 900, 180);
        for (int x = 900; x >= 0; x -= 5) step(0, 0, 200, x, 180);
        step(0, 0, 200, 0, 180);
        step(0, 0, 200, 0, 180);
        check("wrap_score", 32'(score), 32'h002);
        check("wrap_ticks", 32'(tick_seen), 32'd1);

        // Bird above the gap while the pipe overlaps: Lost two edges after the inputs.
        step(0, 0, 100, 210, 180);
        check("hit_lat1", 32'(lost), 32'd0);
        step(0, 0, 100, 210, 180);
        check("hit_lat2", 32'(lost), 32'd1);
        step(0, 0, 200, 140, 180);
        step(0, 0, 200, 140, 180);
        check("lost_frozen", 32'(score), 32'h002);

        // LOST -> IDLE -> PLAY.
        step(0, 1, 200, 1023, 180);
        check("lost_to_idle", 32'(lost), 32'd0);
        check("idle_not_play", 32'(playing), 32'd0);
        check("idle_score_held", 32'(score), 32'h002);
        step(0, 0, 200, 1023, 180);
        step(0, 1, 200, 1023, 180);
        check("idle_to_play", 32'(playing), 32'd1);
        check("play_score0", 32'(score), 32'h000);
        step(0, 0, 200, 1023, 180);

        // Ground boundary: bird top + height reaching the ground row is a collision.
        for (int i = 0; i < 3; i++) step(0, 0, 459, 1023, 180);
        check("ground_459", 32'(playing), 32'd1);
        step(0, 0, 460, 1023, 180);
        step(0, 0, 460, 1023, 180);
        check("ground_460", 32'(lost), 32'd1);
        restart();
        step(0, 0, 461, 1023, 180);
        step(0, 0, 461, 1023, 180);
        check("ground_461", 32'(lost), 32'd1);
        restart();

        // BCD carries and saturation.
        do_passes(9);
        check("bcd_009", 32'(score), 32'h009);
        do_passes(1);
        check("bcd_010", 32'(score), 32'h010);
        do_passes(89);
        check("bcd_099", 32'(score), 32'h099);
        do_passes(1);
        check("bcd_100", 32'(score), 32'h100);
        do_passes(899);
        check("bcd_999", 32'(score), 32'h999);
        t0 = tick_seen;
        do_passes(1);
        check("sat_999", 32'(score), 32'h999);
        check("sat_no_tick", 32'(tick_seen - t0), 32'd0);

        // Reset mid-game.
        check("pre_reset_play", 32'(playing), 32'd1);
        step(1, 0, 200, 1023, 180);
        check("midrst_lost", 32'(lost), 32'd0);
        check("midrst_score", 32'(score), 32'h000);
        check("midrst_tick", 32'(score_tick), 32'd0);
        check("midrst_playing", 32'(playing), 32'd0);
        step(0, 0, 200, 1023, 180);
        check("midrst_idle", 32'(playing), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
